dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word-index bits of internal storage (2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, legal 1..15: cycles from acceptance to dataOK.
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port dcache_mem_req  input  1: request, held by initiator until accepted.
REQ-006 SHALL have port dcache_mem_wr  input  1: 1 write, 0 read.
REQ-007 SHALL have port dcache_mem_size  input  2: 0 byte, 1 half, 2 word.
REQ-008 SHALL have port dcache_mem_wstrb  input  4: byte write enables.
REQ-009 SHALL have port addrout_dcache  input  32: byte address.
REQ-010 SHALL have port dout_dcache_mem  input  32: write data.
REQ-011 SHALL have port din_mem_dcache  output  32: read data.
REQ-012 SHALL have port mem_dcache_addrOK  output  1: request accepted.
REQ-013 SHALL have port mem_dcache_dataOK  output  1: transaction complete / read data valid.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; one transaction outstanding max.
REQ-015 addrOK SHALL be combinational: state==IDLE && req; acceptance = req && addrOK at a rising edge.
REQ-016 On acceptance SHALL latch addr, wr, size, wstrb, wdata; inputs ignored afterwards until IDLE.
REQ-017 Delay counter SHALL load LATENCY-1 on acceptance; BUSY decrements each cycle; at 0 go RESP.
REQ-018 dataOK SHALL be high exactly one cycle (RESP), LATENCY cycles after the acceptance cycle; then IDLE.
REQ-019 Earliest next acceptance SHALL be the cycle after RESP; addrOK low in BUSY and RESP.
REQ-020 Word index SHALL be addr[ADDR_WIDTH+1:2]; upper bits and addr[1:0] ignored (aliasing wrap-around).
REQ-021 Write SHALL update only bytes with wstrb bit set, committed at the edge ending RESP; wstrb=0 completes with no change.
REQ-022 size SHALL not gate the write (wstrb is authoritative); size=3 treated as 2.
REQ-023 Read SHALL return full stored word on din_mem_dcache during RESP; din_mem_dcache SHALL be 0 outside RESP.
REQ-024 Read after write to same word SHALL return updated data when the read is accepted after the write's dataOK.
REQ-025 din_mem_dcache during a write's RESP SHALL be 0.

Reset
REQ-026 rst SHALL force IDLE, counter 0, dataOK 0, din 0 at the next edge; rst dominates acceptance in the same cycle.
REQ-027 rst mid-transaction SHALL abandon it: no dataOK, pending write dropped.
REQ-028 Storage contents SHALL not be reset.

Configuration
REQ-029 Macro DMEM_RESP_JITTER_EN defined: 4-bit LFSR (x^4+x^3+1, reset seed 4'hA, steps every cycle) adds lfsr[1:0] (0..3) extra BUSY cycles, sampled at acceptance.
REQ-030 Macro undefined: latency fixed at LATENCY; no LFSR logic present.

Structure
REQ-031 Package dmem_pkg SHALL hold state enum, size encodings, LFSR seed/width constants.
REQ-032 Storage SHALL be sub-module dmem_sram: byte-enabled word array, one read/write port, async read.

Verification
REQ-033 rst, then write addr 0x10 data 0xDEADBEEF wstrb 4'hF -> addrOK same cycle, dataOK 2 cycles later, din 0.
REQ-034 Read 0x10 -> dataOK at LATENCY, din 0xDEADBEEF; then write 0x10 data 0x000000AA wstrb 4'h1, read -> 0xDEADBEAA.
REQ-035 req held continuously back-to-back -> acceptances spaced LATENCY+1 cycles apart, addrOK low in BUSY/RESP.
REQ-036 ADDR_WIDTH=10: write 0x1000 data 0x12345678, read 0x0000 -> 0x12345678 (alias).
REQ-037 rst asserted in BUSY of a write to 0x20 -> no dataOK; later read of 0x20 returns prior contents.
REQ-038 DMEM_RESP_JITTER_EN defined: 64 reads -> every latency in LATENCY..LATENCY+3, all four values observed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam int             LFSR_W    = 4;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 4'hA;

    // Wide enough for LATENCY-1 (max 14) plus up to 3 jitter cycles.
    localparam int CNT_W = 5;

    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == SIZE_RSVD) ? SIZE_WORD : s;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Byte-enabled 32-bit word array: one port, synchronous write, asynchronous read.
module dmem_sram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            wstrb,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[index][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed (or jittered) response latency.
// Optional DMEM_RESP_JITTER_EN adds 0..3 LFSR-chosen BUSY cycles per transaction.
//
// state | meaning
// IDLE  | ready, addrOK follows req
// BUSY  | transaction latched, counting down latency
// RESP  | dataOK high, read data driven, write commits at end
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dcache_mem_req,
    input  logic        dcache_mem_wr,
    input  logic [1:0]  dcache_mem_size,
    input  logic [3:0]  dcache_mem_wstrb,
    input  logic [31:0] addrout_dcache,
    input  logic [31:0] dout_dcache_mem,
    output logic [31:0] din_mem_dcache,
    output logic        mem_dcache_addrOK,
    output logic        mem_dcache_dataOK
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] load_val;
    logic             accept;

    logic             wr_q;
    logic [1:0]       size_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata;
    logic             sram_we;

`ifdef DMEM_RESP_JITTER_EN
    logic [LFSR_W-1:0] lfsr;

    // x^4 + x^3 + 1, free-running; low two bits pick the extra delay at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
    assign load_val = CNT_W'(LATENCY - 1);
`endif

    assign accept = dcache_mem_req && (state == ST_IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (load_val == '0) begin
                        state_next = ST_RESP;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_BUSY;
                        cnt_next   = load_val;
                    end
                end
            end
            ST_BUSY: begin
                // Leaving BUSY as the count reaches zero gives exactly load_val BUSY cycles.
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_next = ST_RESP;
                    cnt_next   = '0;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            wr_q    <= dcache_mem_wr;
            size_q  <= norm_size(dcache_mem_size);
            wstrb_q <= dcache_mem_wstrb;
            addr_q  <= addrout_dcache;
            wdata_q <= dout_dcache_mem;
        end
    end

    // Reset in RESP drops the write along with the transaction.
    assign sram_we = (state == ST_RESP) && wr_q && !rst;

    dmem_sram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .wstrb (wstrb_q),
        .index (addr_q[ADDR_WIDTH+1:2]),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    // Size and the out-of-range address bits are carried but never steer the access.
    logic unused_bits;
    assign unused_bits = ^{size_q, addr_q[31:ADDR_WIDTH+2], addr_q[1:0]};

    assign mem_dcache_addrOK = accept;
    assign mem_dcache_dataOK = (state == ST_RESP);
    assign din_mem_dcache    = ((state == ST_RESP) && !wr_q) ? rdata : 32'h0;

endmodule
